// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: decode-side valid/ready plus redirects, and the AXI4-Lite read channel.
// The fetch stage uses the master view. The decode/memory environment uses the slave view.
interface fetch_stage_if;
    // Decode side
    logic        valid_out;
    logic        ready_in;
    logic [31:0] PC_IF;
    logic [31:0] IR_IF;
    logic [1:0]  imem_axi_rresp_IF;
    logic        jump_pred_IF;
    logic [31:0] jump_addr_IF;
    logic        jump_mpred_EX;
    logic [31:0] jump_addr_EX;
    // AXI4-Lite read channel
    logic [31:0] imem_axi_araddr;
    logic [2:0]  imem_axi_arprot;
    logic        imem_axi_arvalid;
    logic        imem_axi_arready;
    logic [31:0] imem_axi_rdata;
    logic [1:0]  imem_axi_rresp;
    logic        imem_axi_rvalid;
    logic        imem_axi_rready;

    modport master (
        output valid_out, PC_IF, IR_IF, imem_axi_rresp_IF,
        output imem_axi_araddr, imem_axi_arprot, imem_axi_arvalid, imem_axi_rready,
        input  ready_in, jump_pred_IF, jump_addr_IF, jump_mpred_EX, jump_addr_EX,
        input  imem_axi_arready, imem_axi_rdata, imem_axi_rresp, imem_axi_rvalid
    );

    modport slave (
        input  valid_out, PC_IF, IR_IF, imem_axi_rresp_IF,
        input  imem_axi_araddr, imem_axi_arprot, imem_axi_arvalid, imem_axi_rready,
        output ready_in, jump_pred_IF, jump_addr_IF, jump_mpred_EX, jump_addr_EX,
        output imem_axi_arready, imem_axi_rdata, imem_axi_rresp, imem_axi_rvalid
    );
endinterface

// File: rtl/fetch_stage.sv
// Aurora instruction fetch stage: AXI4-Lite reads with up to DEPTH credits shared between
// in-flight reads and buffered instructions, with redirects on decode predictions and EX
// mispredictions. Wrong-path responses are dropped through a discard counter.
// Optional macro FETCH_BYPASS_EN: when the instruction FIFO is empty and nothing is being
// discarded, the R beat is presented to decode in the same cycle.
module fetch_stage #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int unsigned DEPTH      = 2
) (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.master io_bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
        logic [1:0]  resp;
    } inst_t;

    logic          r_run;
    logic [31:0]   r_fetch_pc;
    logic          r_ar_hold;
    logic [31:0]   r_ar_addr;
    logic [CW-1:0] r_discard;

    logic [31:0]   r_aq_mem [DEPTH];
    logic [PW-1:0] r_aq_wptr;
    logic [PW-1:0] r_aq_rptr;
    logic [CW-1:0] r_aq_cnt;

    inst_t         r_iq_mem [DEPTH];
    logic [PW-1:0] r_iq_wptr;
    logic [PW-1:0] r_iq_rptr;
    logic [CW-1:0] r_iq_cnt;

    logic          w_iq_valid;
    logic          w_byp;
    logic          w_valid;
    logic          w_deq;
    logic          w_iq_pop;
    logic          w_iq_push;
    logic          w_flush;
    logic [31:0]   w_target;
    logic [CW-1:0] w_used;
    logic          w_arvalid;
    logic [31:0]   w_araddr;
    logic          w_ar_hs;
    logic          w_ar_pend;
    logic          w_r_hs;
    inst_t         w_out;

    // Handshakes, credit check, flush decode and output selection.
    always_comb begin
        w_iq_valid = (r_iq_cnt != '0);
`ifdef FETCH_BYPASS_EN
        w_byp = !w_iq_valid && (r_discard == '0) && r_run && io_bus.imem_axi_rvalid;
`else
        w_byp = 1'b0;
`endif
        w_valid  = (w_iq_valid || w_byp) && !io_bus.jump_mpred_EX;
        w_deq    = w_valid && io_bus.ready_in;
        w_iq_pop = w_deq && w_iq_valid;
        w_flush  = io_bus.jump_mpred_EX || (w_deq && io_bus.jump_pred_IF);
        w_target = io_bus.jump_mpred_EX ? io_bus.jump_addr_EX : io_bus.jump_addr_IF;

        // Credits: reads in flight plus buffered entries, counting the entry leaving now.
        w_used    = r_aq_cnt + r_iq_cnt - CW'(w_iq_pop);
        w_arvalid = r_ar_hold || (r_run && (w_used < CW'(DEPTH)));
        w_araddr  = r_ar_hold ? r_ar_addr : r_fetch_pc;
        w_ar_hs   = w_arvalid && io_bus.imem_axi_arready;
        w_ar_pend = w_arvalid && !io_bus.imem_axi_arready;
        w_r_hs    = r_run && io_bus.imem_axi_rvalid;

        // A bypassed beat that decode takes right away never enters the FIFO.
        w_iq_push = w_r_hs && (r_discard == '0) && !w_flush && !(w_deq && !w_iq_valid);

        w_out = r_iq_mem[r_iq_rptr];
        if (w_byp && !w_iq_valid) begin
            w_out = '{pc: r_aq_mem[r_aq_rptr], ir: io_bus.imem_axi_rdata,
                      resp: io_bus.imem_axi_rresp};
        end
    end

    // Fetch PC, AR holding register, discard counter and run flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_run      <= 1'b0;
            r_fetch_pc <= RESET_ADDR;
            r_ar_hold  <= 1'b0;
            r_ar_addr  <= RESET_ADDR;
            r_discard  <= '0;
        end else begin
            r_run     <= 1'b1;
            r_ar_hold <= w_ar_pend;
            r_ar_addr <= w_araddr;
            // A freshly presented address is committed; a stalled one stays in the hold register.
            if (w_flush) begin
                r_fetch_pc <= w_target;
            end else if (w_arvalid && !r_ar_hold) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            // Everything still owed by memory after this cycle, including a stalled AR, is stale.
            if (w_flush) begin
                r_discard <= r_aq_cnt + CW'(w_ar_hs) + CW'(w_ar_pend) - CW'(w_r_hs);
            end else if (w_r_hs && (r_discard != '0)) begin
                r_discard <= r_discard - CW'(1);
            end
        end
    end

    // Address FIFO: PCs accepted on AR and not yet answered on R.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_aq_mem[i] <= '0;
            end
            r_aq_wptr <= '0;
            r_aq_rptr <= '0;
            r_aq_cnt  <= '0;
        end else begin
            if (w_ar_hs) begin
                r_aq_mem[r_aq_wptr] <= w_araddr;
                r_aq_wptr           <= r_aq_wptr + PW'(1);
            end
            if (w_r_hs) begin
                r_aq_rptr <= r_aq_rptr + PW'(1);
            end
            r_aq_cnt <= r_aq_cnt + CW'(w_ar_hs) - CW'(w_r_hs);
        end
    end

    // Instruction FIFO: {PC, IR, RRESP} waiting for decode; emptied on any redirect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_iq_mem[i] <= '0;
            end
            r_iq_wptr <= '0;
            r_iq_rptr <= '0;
            r_iq_cnt  <= '0;
        end else if (w_flush) begin
            r_iq_wptr <= '0;
            r_iq_rptr <= '0;
            r_iq_cnt  <= '0;
        end else begin
            if (w_iq_push) begin
                r_iq_mem[r_iq_wptr] <= '{pc: r_aq_mem[r_aq_rptr], ir: io_bus.imem_axi_rdata,
                                         resp: io_bus.imem_axi_rresp};
                r_iq_wptr           <= r_iq_wptr + PW'(1);
            end
            if (w_iq_pop) begin
                r_iq_rptr <= r_iq_rptr + PW'(1);
            end
            r_iq_cnt <= r_iq_cnt + CW'(w_iq_push) - CW'(w_iq_pop);
        end
    end

    assign io_bus.valid_out         = w_valid;
    assign io_bus.PC_IF             = w_out.pc;
    assign io_bus.IR_IF             = w_out.ir;
    assign io_bus.imem_axi_rresp_IF = w_out.resp;
    assign io_bus.imem_axi_araddr   = w_araddr;
    assign io_bus.imem_axi_arprot   = 3'b100;
    assign io_bus.imem_axi_arvalid  = w_arvalid;
    assign io_bus.imem_axi_rready   = r_run;
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage for the Aurora pipeline. It sits directly upstream of the decode stage. It holds the fetch PC and issues instruction reads over an AXI4-Lite read channel, with up to DEPTH reads in flight. Responses are buffered in a small FIFO and presented to decode as PC_IF/IR_IF/imem_axi_rresp_IF under a valid/ready handshake. It redirects on decode-stage predictions and on EX-stage mispredictions, and discards wrong-path responses.

## Interface
- RESET_ADDR, 32'h00000000, first fetch address after reset
- DEPTH, 2, maximum outstanding reads plus buffered entries (power of two, ≥2)
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- valid_out  out  1  fetched instruction available to decode
- ready_in  in  1  decode accepts the instruction this cycle
- PC_IF  out  32  address of presented instruction
- IR_IF  out  32  presented instruction word
- imem_axi_rresp_IF  out  2  RRESP captured with the instruction
- jump_pred_IF  in  1  decode predicts the presented instruction taken
- jump_addr_IF  in  32  predicted target
- jump_mpred_EX  in  1  EX misprediction, flush and redirect
- jump_addr_EX  in  32  corrected target from EX
- imem_axi_araddr  out  32  read address
- imem_axi_arprot  out  3  constant 3'b100 (instruction, secure, unprivileged)
- imem_axi_arvalid  out  1  read address valid
- imem_axi_arready  in  1  read address accepted
- imem_axi_rdata  in  32  read data
- imem_axi_rresp  in  2  read response
- imem_axi_rvalid  in  1  read data valid
- imem_axi_rready  out  1  read data ready

## Operation
- State: fetch_pc (32), AR holding register, an address FIFO of issued-but-unanswered PCs (DEPTH), an instruction FIFO of {PC, IR, RRESP} (DEPTH), and a discard counter (log2(DEPTH)+1 bits).
- Issue rule: arvalid asserts when the outstanding count plus the instruction-FIFO occupancy is less than DEPTH. On an AR handshake, araddr is pushed to the address FIFO and fetch_pc advances by 4.
- While arvalid=1 and arready=0, araddr and arvalid hold stable, including across a flush.
- rready is always 1 outside reset. The credit rule guarantees FIFO space.
- On an R handshake with discard=0, the head of the address FIFO is popped and {addr, rdata, rresp} is pushed to the instruction FIFO.
- On an R handshake with discard>0, the head is popped, the data is dropped, and discard is decremented.
- Outputs come from the head of the instruction FIFO. valid_out is 1 when the FIFO is not empty. The entry pops on valid_out && ready_in.
- Predicted redirect: on valid_out && ready_in && jump_pred_IF:
  - fetch_pc <= jump_addr_IF
  - the rest of the instruction FIFO is cleared
  - discard <= outstanding count after this cycle's AR/R events
- Mispredict: on jump_mpred_EX, regardless of handshake, the same flush applies with fetch_pc <= jump_addr_EX. valid_out is forced to 0 in that cycle.
- Priority: jump_mpred_EX > jump_pred_IF > sequential increment.
- If an AR is pending (arvalid=1 and not yet accepted) during a flush, that request counts as outstanding and its response is discarded. The redirect target is issued after it.
- RRESP≠OKAY is passed through unchanged. The stage raises no exception itself.

## Timing
- Reset values:
  - valid_out 0; PC_IF, IR_IF 0; imem_axi_rresp_IF 0
  - arvalid 0; araddr RESET_ADDR; rready 0
  - FIFOs empty; discard 0; fetch_pc RESET_ADDR
- First cycle after reset release: arvalid=1, araddr=RESET_ADDR.
- Latency from R handshake to valid_out: 1 cycle (registered FIFO write). See Configuration for the bypass.
- A redirect takes effect on the AR channel in the cycle after the flush, provided no AR is stalled.
- Sustained throughput is 1 instruction/cycle when arready=rvalid=1 and ready_in=1.
- Simultaneous events:
  - Flush and R handshake in the same cycle: that response is counted in discard, not written.
  - Flush and AR handshake in the same cycle: that request is also counted in discard.
- Reset mid-transaction clears all state. Late R beats from the interconnect are the system's responsibility.

## Configuration
- FETCH_BYPASS_EN defined: when the instruction FIFO is empty, discard=0 and rvalid=1, the response drives valid_out/PC_IF/IR_IF/imem_axi_rresp_IF combinationally in the same cycle.
  - If ready_in=1, the entry is consumed without being written.
  - If ready_in=0, it is written to the FIFO as normal.
- FETCH_BYPASS_EN undefined: all outputs come from FIFO registers, giving 1-cycle latency after the R handshake.

## Test plan
- Reset release with arready=rvalid=1 and 1-cycle memory: ARADDR sequence 0x0, 0x4, 0x8. Decode sees PC_IF 0x0, 0x4, 0x8 back-to-back with matching IR_IF.
- ready_in=0 for 5 cycles: at most DEPTH=2 entries are issued and buffered, and arvalid drops. On release, PC_IF continues 0x8, 0xC with no gap or duplicate.
- jump_pred_IF=1 with jump_addr_IF=0x100 while PC_IF=0x4 and 0x8 is in flight: the 0x8 response is discarded, and the next valid_out has PC_IF=0x100.
- jump_mpred_EX=1 with jump_addr_EX=0x40 while arvalid=1 and arready=0 at araddr 0x10: araddr holds 0x10 until accepted, its data is dropped, and the next PC_IF is 0x40.
- rresp=2'b10 on the read of 0x20: the entry is presented with imem_axi_rresp_IF=2'b10 and the fetch stream continues at 0x24.
- With FETCH_BYPASS_EN: empty FIFO, rvalid and ready_in=1 in the same cycle, and valid_out=1 in that cycle. Without the macro: valid_out=1 one cycle later.
